// File: rtl/niosII_system_sysid_pkg.sv
// Shared definitions for the system-ID boot checker: FSM encoding,
// sysid slave word addresses and datapath widths.
package niosII_system_sysid_pkg;

    localparam int DATA_W   = 32;
    localparam int SETTLE_W = 8;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    typedef enum logic [2:0] {
        ST_SETTLE  = 3'd0,
        ST_RD_ID   = 3'd1,
        ST_RD_TS   = 3'd2,
        ST_COMPARE = 3'd3,
        ST_DONE    = 3'd4,
        ST_FAIL    = 3'd5
    } state_t;

    // The CPU owns the sysid slave only once checking has ended.
    function automatic logic is_idle(input state_t st);
        return (st == ST_DONE) || (st == ST_FAIL);
    endfunction

endpackage

// File: rtl/niosII_system_sysid_cmp.sv
// Dual 32-bit equality compare. all_match is the live result used by the
// FSM decision; id_ok/ts_ok hold the result latched on the load strobe.
module niosII_system_sysid_cmp
    import niosII_system_sysid_pkg::*;
#(
    parameter logic [DATA_W-1:0] EXPECTED_ID        = 32'd0,
    parameter logic [DATA_W-1:0] EXPECTED_TIMESTAMP = 32'd1486319916
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              load,
    input  logic [DATA_W-1:0] id_word,
    input  logic [DATA_W-1:0] ts_word,
    output logic              all_match,
    output logic              id_ok,
    output logic              ts_ok
);

    logic [DATA_W-1:0] word     [2];
    logic [DATA_W-1:0] expected [2];
    logic              match    [2];
    logic              ok_reg   [2];

    assign word[0]     = id_word;
    assign word[1]     = ts_word;
    assign expected[0] = EXPECTED_ID;
    assign expected[1] = EXPECTED_TIMESTAMP;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            assign match[gi] = (word[gi] == expected[gi]);

            // Latch this lane's compare result when the FSM is in COMPARE.
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    ok_reg[gi] <= 1'b0;
                end else if (load) begin
                    ok_reg[gi] <= match[gi];
                end
            end
        end
    endgenerate

    assign all_match = match[0] & match[1];
    assign id_ok     = ok_reg[0];
    assign ts_ok     = ok_reg[1];

endmodule

// File: rtl/niosii_system_sysid_checker.sv
// Boot-time sysid checker: reads ID and timestamp words, compares them,
// holds the CPU in reset until they match (bounded retries), then passes
// CPU reads through to the sysid slave with zero wait states.
module niosii_system_sysid_checker
    import niosII_system_sysid_pkg::*;
#(
    parameter logic [DATA_W-1:0] EXPECTED_ID        = 32'd0,
    parameter logic [DATA_W-1:0] EXPECTED_TIMESTAMP = 32'd1486319916,
    parameter int unsigned       SETTLE_CYCLES      = 4,
    parameter int unsigned       MAX_RETRIES        = 3
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic              cpu_address,
    input  logic              cpu_read,
    output logic [DATA_W-1:0] cpu_readdata,
    output logic              cpu_waitrequest,
    output logic              sysid_address,
    input  logic [DATA_W-1:0] sysid_readdata,
    output logic              boot_hold,
    output logic              check_done,
    output logic              id_ok,
    output logic              ts_ok,
    output logic [1:0]        retry_count
);

    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [1:0]          RETRY_LIMIT = 2'(MAX_RETRIES);

    state_t              state_reg;
    logic [SETTLE_W-1:0] settle_cnt_reg;
    logic [1:0]          retry_count_reg;
    logic [DATA_W-1:0]   id_reg;
    logic [DATA_W-1:0]   ts_reg;
    logic                boot_hold_reg;
    logic                check_done_reg;
    logic                all_match;

    niosII_system_sysid_cmp #(
        .EXPECTED_ID        (EXPECTED_ID),
        .EXPECTED_TIMESTAMP (EXPECTED_TIMESTAMP)
    ) u_cmp (
        .clock     (clock),
        .reset_n   (reset_n),
        .load      (state_reg == ST_COMPARE),
        .id_word   (id_reg),
        .ts_word   (ts_reg),
        .all_match (all_match),
        .id_ok     (id_ok),
        .ts_ok     (ts_ok)
    );

    // Check sequencer: settle, read both words, compare, retry or finish.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= ST_SETTLE;
            settle_cnt_reg  <= '0;
            retry_count_reg <= '0;
            id_reg          <= '0;
            ts_reg          <= '0;
            boot_hold_reg   <= 1'b1;
            check_done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_SETTLE: begin
                    if (settle_cnt_reg == SETTLE_LAST) begin
                        settle_cnt_reg <= '0;
                        state_reg      <= ST_RD_ID;
                    end else begin
                        settle_cnt_reg <= settle_cnt_reg + 1'b1;
                    end
                end
                ST_RD_ID: begin
                    id_reg    <= sysid_readdata;
                    state_reg <= ST_RD_TS;
                end
                ST_RD_TS: begin
                    ts_reg    <= sysid_readdata;
                    state_reg <= ST_COMPARE;
                end
                ST_COMPARE: begin
                    if (all_match) begin
                        state_reg      <= ST_DONE;
                        boot_hold_reg  <= 1'b0;
                        check_done_reg <= 1'b1;
                    end else if (retry_count_reg < RETRY_LIMIT) begin
                        retry_count_reg <= retry_count_reg + 1'b1;
                        state_reg       <= ST_SETTLE;
                    end else begin
                        state_reg      <= ST_FAIL;
                        boot_hold_reg  <= 1'b1;
                        check_done_reg <= 1'b1;
                    end
                end
                ST_DONE, ST_FAIL: begin
                    // A recheck re-holds the CPU immediately; id_ok/ts_ok
                    // keep their last values until the next COMPARE.
                    if (start) begin
                        retry_count_reg <= '0;
                        check_done_reg  <= 1'b0;
                        boot_hold_reg   <= 1'b1;
                        state_reg       <= ST_SETTLE;
                    end
                end
                default: begin
                    state_reg <= ST_SETTLE;
                end
            endcase
        end
    end

    // Slave-port ownership: CPU pass-through when idle, checker otherwise.
    always_comb begin
        cpu_readdata    = '0;
        cpu_waitrequest = cpu_read;
        sysid_address   = SYSID_ADDR_ID;
        if (is_idle(state_reg)) begin
            sysid_address   = cpu_address;
            cpu_readdata    = sysid_readdata;
            cpu_waitrequest = 1'b0;
        end else if (state_reg == ST_RD_TS) begin
            sysid_address = SYSID_ADDR_TS;
        end
    end

    assign boot_hold   = boot_hold_reg;
    assign check_done  = check_done_reg;
    assign retry_count = retry_count_reg;

endmodule

// File: tb/tb_niosii_system_sysid_checker.sv
// Scoreboard bench for the sysid boot checker. Stimulus computes the
// expected outcome of each check from per-pass slave contents and queues
// it; a negedge monitor compares whenever check_done rises or a CPU read
// completes.
module tb_niosii_system_sysid_checker;

    localparam logic [31:0] EXP_ID   = 32'd0;
    localparam logic [31:0] EXP_TS   = 32'd1486319916;
    localparam int          S        = 4;
    localparam int          MAXR     = 3;
    localparam int          PASS_LEN = S + 3;

    logic        clock       = 1'b0;
    logic        reset_n     = 1'b0;
    logic        start       = 1'b0;
    logic        cpu_address = 1'b0;
    logic        cpu_read    = 1'b0;
    logic [31:0] cpu_readdata;
    logic        cpu_waitrequest;
    logic        sysid_address;
    logic [31:0] sysid_readdata;
    logic        boot_hold;
    logic        check_done;
    logic        id_ok;
    logic        ts_ok;
    logic [1:0]  retry_count;

    // Behavioural sysid slave: combinational in address.
    logic [31:0] slave_id = 32'd0;
    logic [31:0] slave_ts = 32'd0;
    assign sysid_readdata = sysid_address ? slave_ts : slave_id;

    niosii_system_sysid_checker #(
        .EXPECTED_ID        (EXP_ID),
        .EXPECTED_TIMESTAMP (EXP_TS),
        .SETTLE_CYCLES      (S),
        .MAX_RETRIES        (MAXR)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .start           (start),
        .cpu_address     (cpu_address),
        .cpu_read        (cpu_read),
        .cpu_readdata    (cpu_readdata),
        .cpu_waitrequest (cpu_waitrequest),
        .sysid_address   (sysid_address),
        .sysid_readdata  (sysid_readdata),
        .boot_hold       (boot_hold),
        .check_done      (check_done),
        .id_ok           (id_ok),
        .ts_ok           (ts_ok),
        .retry_count     (retry_count)
    );

    always #5 clock = ~clock;

    // Edges counted only while out of reset.
    int edge_cnt = 0;
    always @(posedge clock) if (reset_n) edge_cnt <= edge_cnt + 1;

    typedef struct {
        int         edge_no;
        logic       hold;
        logic       idok;
        logic       tsok;
        logic [1:0] retry;
    } done_exp_t;

    typedef struct {
        int          edge_no;
        logic [31:0] data;
    } rd_exp_t;

    done_exp_t done_q[$];
    rd_exp_t   rd_q[$];

    int tests_run = 0;
    int failed    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // Monitor: one line per completed check and per completed CPU read.
    logic      prev_done = 1'b0;
    done_exp_t mon_de;
    rd_exp_t   mon_re;
    always @(negedge clock) begin
        if (check_done && !prev_done) begin
            if (done_q.size() == 0) begin
                chk("done_unexpected", 32'd1, 32'd0);
            end else begin
                mon_de = done_q.pop_front();
                $display("[TB] check done edge=%0d hold=%0b id_ok=%0b ts_ok=%0b retry=%0d",
                         edge_cnt, boot_hold, id_ok, ts_ok, retry_count);
                chk("done_edge",   edge_cnt,    mon_de.edge_no);
                chk("boot_hold",   boot_hold,   mon_de.hold);
                chk("id_ok",       id_ok,       mon_de.idok);
                chk("ts_ok",       ts_ok,       mon_de.tsok);
                chk("retry_count", retry_count, mon_de.retry);
            end
        end
        prev_done = check_done;
        if (cpu_read && !cpu_waitrequest) begin
            if (rd_q.size() == 0) begin
                chk("read_unexpected", 32'd1, 32'd0);
            end else begin
                mon_re = rd_q.pop_front();
                $display("[TB] cpu read addr=%0d data=0x%08h edge=%0d", cpu_address, cpu_readdata, edge_cnt);
                chk("read_edge", edge_cnt,     mon_re.edge_no);
                chk("read_data", cpu_readdata, mon_re.data);
            end
        end
    end

    logic [31:0] pass_id [4];
    logic [31:0] pass_ts [4];
    logic        last_id_ok = 1'b0;

    // Advance (at posedge+1) until edge_cnt reaches target, bounded.
    task automatic wait_edge(input int target);
        int guard = 0;
        while (edge_cnt < target && guard < 2000) begin
            @(posedge clock);
            #1;
            guard++;
        end
        if (edge_cnt < target) chk("wait_bound", 32'(edge_cnt), 32'(target));
    endtask

    // kind 0: release reset; 1: release reset with a CPU read held;
    // kind 2: pulse start; 3: pulse start together with a CPU read.
    task automatic run_check(input int kind, input logic rd_addr);
        int        p;
        int        base;
        int        done_edge;
        logic      ok;
        done_exp_t de;
        rd_exp_t   re;
        p = 0;
        while (!(pass_id[p] == EXP_ID && pass_ts[p] == EXP_TS) && p < MAXR) p++;
        ok = (pass_id[p] == EXP_ID) && (pass_ts[p] == EXP_TS);
        slave_id = pass_id[0];
        slave_ts = pass_ts[0];
        if (kind < 2) begin
            base = edge_cnt;
            if (kind == 1) begin
                cpu_address = rd_addr;
                cpu_read    = 1'b1;
            end
            reset_n = 1'b1;
        end else begin
            base  = edge_cnt + 1;
            start = 1'b1;
            if (kind == 3) begin
                cpu_address = rd_addr;
                cpu_read    = 1'b1;
                re.edge_no  = edge_cnt;
                re.data     = rd_addr ? slave_ts : slave_id;
                rd_q.push_back(re);
            end
        end
        done_edge  = base + (p + 1) * PASS_LEN;
        de.edge_no = done_edge;
        de.hold    = !ok;
        de.idok    = (pass_id[p] == EXP_ID);
        de.tsok    = (pass_ts[p] == EXP_TS);
        de.retry   = 2'(p);
        done_q.push_back(de);
        if (kind == 1) begin
            re.edge_no = done_edge;
            re.data    = rd_addr ? pass_ts[p] : pass_id[p];
            rd_q.push_back(re);
        end
        if (kind >= 2) begin
            @(posedge clock);
            #1;
            start    = 1'b0;
            cpu_read = 1'b0;
            chk("hold_after_start", boot_hold, 1'b1);
            chk("done_after_start", check_done, 1'b0);
            chk("id_ok_kept", id_ok, last_id_ok);
        end
        for (int q = 1; q <= p; q++) begin
            wait_edge(base + q * PASS_LEN);
            slave_id = pass_id[q];
            slave_ts = pass_ts[q];
        end
        wait_edge(done_edge + 1);
        cpu_read = 1'b0;
        chk("done_seen", 32'(done_q.size()), 32'd0);
        last_id_ok = de.idok;
    endtask

    task automatic apply_reset();
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        repeat (2) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic set_passes(input logic [31:0] id0, input logic [31:0] ts0,
                              input logic [31:0] idn, input logic [31:0] tsn);
        pass_id[0] = id0;
        pass_ts[0] = ts0;
        for (int i = 1; i < 4; i++) begin
            pass_id[i] = idn;
            pass_ts[i] = tsn;
        end
    endtask

    task automatic rand_passes();
        for (int i = 0; i < 4; i++) begin
            pass_id[i] = ($urandom_range(0, 3) == 0) ? ($urandom | 32'd1) : EXP_ID;
            pass_ts[i] = ($urandom_range(0, 2) == 0) ? (EXP_TS ^ (32'd1 << $urandom_range(0, 31))) : EXP_TS;
        end
    endtask

    task automatic idle_reads(input int n);
        rd_exp_t re;
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
            slave_id    = $urandom;
            slave_ts    = $urandom;
            cpu_address = 1'($urandom_range(0, 1));
            cpu_read    = 1'b1;
            re.edge_no  = edge_cnt;
            re.data     = cpu_address ? slave_ts : slave_id;
            rd_q.push_back(re);
            @(posedge clock);
            #1;
            cpu_read = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got still running, expected finished");
        $fatal(1, "time limit reached");
    end

    initial begin
        int base;
        // Reset state.
        repeat (2) @(posedge clock);
        #1;
        cpu_read = 1'b1;
        #1;
        chk("rst_waitrequest_rd", cpu_waitrequest, 1'b1);
        chk("rst_readdata",       cpu_readdata,    32'd0);
        chk("rst_boot_hold",      boot_hold,       1'b1);
        chk("rst_check_done",     check_done,      1'b0);
        chk("rst_id_ok",          id_ok,           1'b0);
        chk("rst_ts_ok",          ts_ok,           1'b0);
        chk("rst_retry",          retry_count,     2'd0);
        chk("rst_sysid_address",  sysid_address,   1'b0);
        cpu_read = 1'b0;
        #1;
        chk("rst_waitrequest_idle", cpu_waitrequest, 1'b0);
        @(posedge clock);
        #1;

        // Matching slave, CPU read of the timestamp held through the check.
        set_passes(EXP_ID, EXP_TS, EXP_ID, EXP_TS);
        run_check(1, 1'b1);
        idle_reads(3);

        // Recheck with a simultaneous CPU read.
        set_passes(EXP_ID, EXP_TS, EXP_ID, EXP_TS);
        run_check(3, 1'b1);

        // Timestamp always wrong: all retries consumed, then FAIL.
        apply_reset();
        set_passes(EXP_ID, 32'd0, EXP_ID, 32'd0);
        run_check(0, 1'b0);
        idle_reads(2);

        // First pass wrong, corrected for the second.
        apply_reset();
        set_passes(EXP_ID, 32'd0, EXP_ID, EXP_TS);
        run_check(0, 1'b0);

        // Reset in the middle of a recheck, during RD_TS.
        @(posedge clock);
        #1;
        start = 1'b1;
        base  = edge_cnt + 1;
        @(posedge clock);
        #1;
        start = 1'b0;
        wait_edge(base + S + 1);
        chk("rd_ts_address", sysid_address, 1'b1);
        chk("mid_id_ok_kept", id_ok, 1'b1);
        cpu_read = 1'b1;
        reset_n  = 1'b0;
        #1;
        chk("mid_rst_sysid_address", sysid_address,   1'b0);
        chk("mid_rst_id_ok",         id_ok,           1'b0);
        chk("mid_rst_ts_ok",         ts_ok,           1'b0);
        chk("mid_rst_boot_hold",     boot_hold,       1'b1);
        chk("mid_rst_waitrequest",   cpu_waitrequest, 1'b1);
        chk("mid_rst_readdata",      cpu_readdata,    32'd0);
        cpu_read = 1'b0;
        repeat (2) begin
            @(posedge clock);
            #1;
        end
        set_passes(EXP_ID, EXP_TS, EXP_ID, EXP_TS);
        run_check(0, 1'b0);

        // Randomized checks mixing rechecks, resets and idle reads.
        for (int it = 0; it < 12; it++) begin
            rand_passes();
            if ($urandom_range(0, 3) == 0) begin
                apply_reset();
                run_check(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end else begin
                run_check(int'($urandom_range(2, 3)), 1'($urandom_range(0, 1)));
            end
            idle_reads(int'($urandom_range(1, 3)));
        end

        repeat (2) @(posedge clock);
        #1;
        chk("done_queue_empty", 32'(done_q.size()), 32'd0);
        chk("read_queue_empty", 32'(rd_q.size()),   32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule

// File: doc/niosii_system_sysid_checker.md
# niosII_system_sysid_checker

Boot-time controller and access arbiter for the system-ID slave in the niosII_system. After reset it reads the slave's ID word (address 0) and build timestamp (address 1), then compares both against expected values. It holds the CPU in reset-request until they match, retrying a bounded number of times. Once checking ends, it passes CPU reads on its Avalon-MM slave port through to the system-ID slave, which it masters.

## Interface
- EXPECTED_ID, default 0: required word at sysid address 0.
- EXPECTED_TIMESTAMP, default 1486319916: required word at sysid address 1.
- SETTLE_CYCLES, default 4 (range 1..255): idle cycles before each check pass.
- MAX_RETRIES, default 3 (range 0..3): extra passes allowed after a failed compare.
- clock, in, 1: system clock.
- reset_n, in, 1: asynchronous, active-low reset.
- start, in, 1: single-cycle recheck request, honoured only in DONE or FAIL.
- cpu_address, in, 1: CPU word address.
- cpu_read, in, 1: CPU read strobe.
- cpu_readdata, out, 32: CPU read data.
- cpu_waitrequest, out, 1: CPU stall.
- sysid_address, out, 1: address driven to the sysid slave.
- sysid_readdata, in, 32: sysid slave data, combinational in sysid_address.
- boot_hold, out, 1: CPU reset request, 1 = hold.
- check_done, out, 1: check pass finished (pass or final fail).
- id_ok, out, 1: last compare result for the ID word.
- ts_ok, out, 1: last compare result for the timestamp word.
- retry_count, out, 2: retries consumed in the current check.

## Operation
- States: SETTLE, RD_ID, RD_TS, COMPARE, DONE, FAIL.
- SETTLE: 8-bit counter runs from 0 to SETTLE_CYCLES-1, then the FSM goes to RD_ID. sysid_address = 0.
- RD_ID: sysid_address = 0; sysid_readdata is captured into id_reg at the end of the cycle. Next state is RD_TS.
- RD_TS: sysid_address = 1; sysid_readdata is captured into ts_reg. Next state is COMPARE.
- COMPARE: register id_ok = (id_reg == EXPECTED_ID) and ts_ok = (ts_reg == EXPECTED_TIMESTAMP).
  - Both ok: go to DONE.
  - Else, if retry_count < MAX_RETRIES: increment retry_count and go to SETTLE.
  - Else: go to FAIL.
- DONE: boot_hold = 0, check_done = 1.
- FAIL: boot_hold = 1, check_done = 1.
- In DONE or FAIL, start = 1 causes:
  - retry_count cleared, check_done cleared;
  - next state SETTLE, with boot_hold reasserted on that same edge;
  - id_ok and ts_ok keep their values until the next COMPARE.
- start is ignored in all other states.
- CPU arbitration:
  - In DONE or FAIL: sysid_address = cpu_address, cpu_readdata = sysid_readdata, cpu_waitrequest = 0. Reads complete in zero wait states.
  - In all other states: cpu_waitrequest = cpu_read, cpu_readdata = 0, and the checker owns sysid_address.
- start and cpu_read asserted together in DONE: the CPU read completes in that cycle, and the FSM moves to SETTLE on the next edge.

## Timing
- Reset values: state SETTLE, counter 0, retry_count 0, id_reg = ts_reg = 0, id_ok = ts_ok = 0, check_done = 0, boot_hold = 1, sysid_address = 0, cpu_readdata = 0.
- cpu_waitrequest = cpu_read while reset_n is low.
- Reset asserted mid-pass: the FSM aborts immediately and all outputs take their reset values. No partial result survives.
- Pass latency: a clean pass reaches DONE on rising edge SETTLE_CYCLES+3 after reset release. Edges are counted from the first edge with reset_n high.
- Each retry adds SETTLE_CYCLES+3 cycles.
- boot_hold, check_done, id_ok, ts_ok and retry_count are all registered.
- cpu_waitrequest, cpu_readdata and sysid_address are combinational from state and the CPU inputs.

## Structure
- Shared package niosII_system_sysid_pkg holds:
  - state encodings (3-bit);
  - SYSID_ADDR_ID = 0 and SYSID_ADDR_TS = 1;
  - data width 32 and settle counter width 8.
- One sub-module is natural: niosII_system_sysid_cmp, a registered dual 32-bit equality compare producing id_ok and ts_ok on a load strobe.
- The FSM, counters and pass-through mux live in the top module.

## Test plan
- Matching slave (ID 0, timestamp 1486319916), SETTLE_CYCLES 4, reset released → check_done = 1, boot_hold = 0, id_ok = ts_ok = 1 on edge 7, retry_count = 0.
- Slave timestamp 0, MAX_RETRIES 3 → four passes, then FAIL: retry_count = 3, ts_ok = 0, id_ok = 1, boot_hold = 1, check_done at edge 28.
- Slave mismatched for the first pass, corrected before the second pass → DONE with retry_count = 1, boot_hold = 0 at edge 14.
- cpu_read at address 1 held during the check → waitrequest stays 1 until DONE. Then in the same cycle the read returns 1486319916 with waitrequest = 0.
- start pulsed in DONE together with cpu_read → that read completes. Next cycle boot_hold = 1, check_done = 0, and DONE is re-reached 7 cycles later.
- reset_n pulsed low during RD_TS → outputs take reset values asynchronously, and a full pass restarts from SETTLE.
